// File: rtl/msg_rx_ctrl_pkg.sv
// ============================================================================
//  Module   : msg_rx_ctrl_pkg
//  Purpose  : Shared receive-controller types: FSM encoding, default width and
//             serial line levels. The matching transmit controller uses these too.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package msg_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2,
      STOP = 2'd3
   } rx_state_t;

   localparam int   c_msg_w_default = 8;
   localparam logic c_line_idle     = 1'b1;
   localparam logic c_line_start    = 1'b0;
   localparam logic c_line_stop     = 1'b1;

endpackage

`default_nettype wire

// File: rtl/msg_bit_cntr.sv
// ============================================================================
//  Module   : msg_bit_cntr
//  Purpose  : Clear/enable data-bit counter; tc flags the last data bit and
//             the count saturates there instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module msg_bit_cntr #(
   parameter int MSG_W = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (MSG_W > 1) ? $clog2(MSG_W) : 1;
   localparam logic [CW-1:0] c_last = CW'(MSG_W - 1);

   logic [CW-1:0] r_cnt;
   logic          w_tc;

   assign w_tc = (r_cnt == c_last);
   assign tc   = w_tc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en && !w_tc) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/msg_rx_ctrl.sv
// ============================================================================
//  Module   : msg_rx_ctrl
//  Purpose  : Frames a sampled serial stream (start, MSG_W data LSB first,
//             optional even parity, stop) into words with valid/error pulses.
//             Parity is enabled by defining MSG_RX_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module msg_rx_ctrl
   import msg_rx_ctrl_pkg::*;
#(
   parameter int MSG_W = c_msg_w_default
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_bit,
   input  logic             bit_tick,
   output logic [MSG_W-1:0] msg,
   output logic             msg_valid,
   output logic             frame_err,
   output logic             parity_err,
   output logic             busy
);

   rx_state_t        r_state, w_state_nxt;
   logic [MSG_W-1:0] r_sh;
   logic [MSG_W-1:0] r_msg;
   logic             r_valid, r_ferr, r_busy;
   logic             w_valid_nxt, w_ferr_nxt, w_perr_nxt;
   logic             w_cnt_clr, w_cnt_en, w_sh_en, w_tc, w_perr;

   msg_bit_cntr #(
      .MSG_W (MSG_W)
   ) u_bit_cntr (
      .clk   (clk),
      .reset (reset),
      .clr   (w_cnt_clr),
      .en    (w_cnt_en),
      .tc    (w_tc)
   );

`ifdef MSG_RX_PARITY_EN
   logic r_rx_par, r_perr, w_par_cap;

   // Even parity over data plus the received parity bit must come out 0.
   assign w_perr = ^{r_sh, r_rx_par};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_par <= 1'b0;
         r_perr   <= 1'b0;
      end else begin
         if (w_par_cap) r_rx_par <= rx_bit;
         r_perr <= w_perr_nxt;
      end
   end

   assign parity_err = r_perr;
`else
   assign w_perr     = 1'b0;
   assign parity_err = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_cnt_en    = 1'b0;
      w_sh_en     = 1'b0;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;
      w_perr_nxt  = 1'b0;
`ifdef MSG_RX_PARITY_EN
      w_par_cap   = 1'b0;
`endif
      if (bit_tick) begin
         case (r_state)
            IDLE: begin
               if (rx_bit == c_line_start) begin
                  w_state_nxt = DATA;
                  w_cnt_clr   = 1'b1;
               end
            end
            DATA: begin
               w_sh_en  = 1'b1;
               w_cnt_en = 1'b1;
               if (w_tc) begin
`ifdef MSG_RX_PARITY_EN
                  w_state_nxt = PAR;
`else
                  w_state_nxt = STOP;
`endif
               end
            end
            PAR: begin
`ifdef MSG_RX_PARITY_EN
               w_par_cap   = 1'b1;
               w_state_nxt = STOP;
`else
               w_state_nxt = IDLE;
`endif
            end
            STOP: begin
               // A bad stop bit masks any parity error on the same frame.
               if (rx_bit != c_line_stop) begin
                  w_ferr_nxt = 1'b1;
               end else if (w_perr) begin
                  w_perr_nxt = 1'b1;
               end else begin
                  w_valid_nxt = 1'b1;
               end
               w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_sh    <= '0;
         r_msg   <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_sh_en) r_sh <= {rx_bit, r_sh[MSG_W-1:1]};
         if (w_valid_nxt) r_msg <= r_sh;
         r_valid <= w_valid_nxt;
         r_ferr  <= w_ferr_nxt;
         r_busy  <= (w_state_nxt != IDLE);
      end
   end

   assign msg       = r_msg;
   assign msg_valid = r_valid;
   assign frame_err = r_ferr;
   assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_msg_rx_ctrl.sv
// ============================================================================
//  Module   : tb_msg_rx_ctrl
//  Purpose  : Self-checking bench for msg_rx_ctrl (MSG_W=8), directed and
//             randomized frames against a frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_msg_rx_ctrl;

   localparam int MSG_W = 8;
`ifdef MSG_RX_PARITY_EN
   localparam int FRAME_LEN = MSG_W + 3;
`else
   localparam int FRAME_LEN = MSG_W + 2;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             rx_bit;
   logic             bit_tick;
   logic [MSG_W-1:0] msg;
   logic             msg_valid;
   logic             frame_err;
   logic             parity_err;
   logic             busy;

   int               checks   = 0;
   int               failures = 0;
   int               cyc      = 0;
   logic [MSG_W-1:0] exp_msg;
   int               valid_cycles[$];

   msg_rx_ctrl #(
      .MSG_W (MSG_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_bit     (rx_bit),
      .bit_tick   (bit_tick),
      .msg        (msg),
      .msg_valid  (msg_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (msg_valid === 1'b1) valid_cycles.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic b, input logic t);
      @(negedge clk);
      rx_bit   = b;
      bit_tick = t;
      @(posedge clk);
      #1;
   endtask

   // Pulses packed as {msg_valid, frame_err, parity_err}.
   task automatic chk_quiet(input string tag, input logic exp_busy);
      chk({tag, "_pulses"}, 32'({msg_valid, frame_err, parity_err}), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
      chk({tag, "_msg"}, 32'(msg), 32'(exp_msg));
   endtask

   task automatic send_frame(input string tag, input logic [MSG_W-1:0] d, input logic stop,
                             input logic par_flip, input int gap);
      logic bits[$];
      logic bad_par;
      logic [2:0] exp_pulses;
      bits = {};
      bits.push_back(1'b0);
      for (int i = 0; i < MSG_W; i++) bits.push_back(d[i]);
`ifdef MSG_RX_PARITY_EN
      bits.push_back((^d) ^ par_flip);
      bad_par = par_flip;
`else
      bad_par = 1'b0;
`endif
      bits.push_back(stop);
      for (int i = 0; i < bits.size(); i++) begin
         step(bits[i], 1'b1);
         if (i == bits.size() - 1) begin
            if (!stop)        exp_pulses = 3'b010;
            else if (bad_par) exp_pulses = 3'b001;
            else begin
               exp_pulses = 3'b100;
               exp_msg    = d;
            end
            chk({tag, "_end_pulses"}, 32'({msg_valid, frame_err, parity_err}), 32'(exp_pulses));
            chk({tag, "_end_msg"}, 32'(msg), 32'(exp_msg));
            chk({tag, "_end_busy"}, 32'(busy), 32'd0);
         end else begin
            chk_quiet({tag, "_mid"}, 1'b1);
         end
         for (int g = 0; g < gap; g++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            chk_quiet({tag, "_gap"}, (i != bits.size() - 1));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      rx_bit   = 1'b1;
      bit_tick = 1'b0;
      exp_msg  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_msg", 32'(msg), 32'd0);
      chk("reset_pulses", 32'({msg_valid, frame_err, parity_err}), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Good frame with gaps between ticks and noise on non-tick cycles.
      send_frame("t1_a5", 8'hA5, 1'b1, 1'b0, 2);
      step(1'b1, 1'b0);
      chk_quiet("t1_after", 1'b0);

      send_frame("t2_ferr", 8'hA5, 1'b0, 1'b0, 1);

      // Reset after three data bits.
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      chk("t3_busy_pre", 32'(busy), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      exp_msg = '0;
      chk("t3_busy_rst", 32'(busy), 32'd0);
      chk("t3_msg_rst", 32'(msg), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      send_frame("t3_3c", 8'h3C, 1'b1, 1'b0, 1);

      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0);
         chk_quiet("t4_low", 1'b0);
      end
      step(1'b1, 1'b1);
      chk_quiet("t4_idle_tick", 1'b0);

      // Tick every cycle, frames back to back.
      valid_cycles = {};
      send_frame("t5_01", 8'h01, 1'b1, 1'b0, 0);
      send_frame("t5_ff", 8'hFF, 1'b1, 1'b0, 0);
      step(1'b1, 1'b1);
      chk("t5_npulses", 32'(valid_cycles.size()), 32'd2);
      if (valid_cycles.size() == 2)
         chk("t5_spacing", 32'(valid_cycles[1] - valid_cycles[0]), 32'(FRAME_LEN));

`ifdef MSG_RX_PARITY_EN
      send_frame("t6_par_ok", 8'hA5, 1'b1, 1'b0, 1);
      send_frame("t6_par_bad", 8'hA5, 1'b1, 1'b1, 1);
      send_frame("t6_both", 8'h5A, 1'b0, 1'b1, 1);
`endif

      for (int n = 0; n < 24; n++) begin
         send_frame("rnd", MSG_W'($urandom), ($urandom_range(0, 4) != 0),
                    ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
